device_tick_gen: RTL and testbench

- Multi-channel programmable tick generator; next generation of the single-channel fixed-period device clock counter.
- Each channel emits one-clock-wide `tick` pulses at a software-programmable period, in either periodic or one-shot mode.
- Ticks are used as clock enables by display scan, keypad debounce, UART baud and timer peripherals in the IO subsystem.
- Runtime-reprogrammable through a simple single-cycle write port.

---
 rtl/io_tick_pkg.sv | 26 ++
 rtl/tick_channel.sv | 74 +++++++
 rtl/device_tick_gen.sv | 93 +++++++++
 tb/tb_device_tick_gen.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_tick_pkg.sv
// -----------------------------------------------------------------------------
// io_tick_pkg
// Shared types and default constants for the IO-subsystem tick generator.
//   TICK_CNT_W       : default counter/divisor width
//   TICK_DEFAULT_DIV : default divisor loaded at reset (period = DIV+1)
//   tick_mode_e      : periodic / one-shot channel mode
//   tick_ctrl_t      : per-channel control record (div, run, mode) at the
//                      default width
// -----------------------------------------------------------------------------
package io_tick_pkg;

    localparam int unsigned TICK_CNT_W       = 16;
    localparam int unsigned TICK_DEFAULT_DIV = 25000;

    typedef enum logic {
        TICK_PERIODIC = 1'b0,
        TICK_ONESHOT  = 1'b1
    } tick_mode_e;

    typedef struct packed {
        logic [TICK_CNT_W-1:0] div;
        logic                  run;
        tick_mode_e            mode;
    } tick_ctrl_t;

endpackage

// File: rtl/tick_channel.sv
// -----------------------------------------------------------------------------
// tick_channel
// One programmable tick channel: counter, divisor, run state and mode.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   ce           : count enable (1 every cycle unless prescaled)
//   wr_sel       : decoded write strobe for this channel
//   wr_div       : new divisor
//   wr_run       : 1 = start, 0 = stop
//   wr_mode      : periodic / one-shot
//   tick         : one-cycle pulse when cnt reaches div on a ce cycle
//   running      : registered run status
// -----------------------------------------------------------------------------
module tick_channel
    import io_tick_pkg::*;
#(
    parameter int unsigned CNT_W       = TICK_CNT_W,
    parameter int unsigned DEFAULT_DIV = TICK_DEFAULT_DIV,
    parameter bit          RESET_EN    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             wr_sel,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             wr_run,
    input  tick_mode_e       wr_mode,
    output logic             tick,
    output logic             running
);

    typedef enum logic {
        CH_IDLE  = 1'b0,
        CH_COUNT = 1'b1
    } ch_state_e;

    ch_state_e        state_q;
    tick_mode_e       mode_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] div_q;
    logic             hit;

    assign hit = (cnt_q == div_q);

    // A write takes priority over the terminal-count update, so a write in
    // the same cycle as a one-shot tick keeps the channel in the written state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            div_q   <= CNT_W'(DEFAULT_DIV);
            state_q <= RESET_EN ? CH_COUNT : CH_IDLE;
            mode_q  <= TICK_PERIODIC;
        end else if (wr_sel) begin
            cnt_q   <= '0;
            div_q   <= wr_div;
            state_q <= wr_run ? CH_COUNT : CH_IDLE;
            mode_q  <= wr_mode;
        end else if (state_q == CH_COUNT && ce) begin
            if (hit) begin
                cnt_q <= '0;
                if (mode_q == TICK_ONESHOT) begin
                    state_q <= CH_IDLE;
                end
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Derived only from flops and ce, so glitch-free at the use sites.
    assign tick    = (state_q == CH_COUNT) && ce && hit;
    assign running = (state_q == CH_COUNT);

endmodule

// File: rtl/device_tick_gen.sv
// -----------------------------------------------------------------------------
// device_tick_gen
// Multi-channel programmable tick generator with a single-cycle write port.
// Optional shared prescaler compiled in with macro TICK_GEN_PRESCALE_EN;
// without it every channel counts on every clock.
// Ports:
//   clk, rst_n   : clock, synchronous active-low reset
//   wr_en        : single-cycle write strobe
//   wr_ch        : target channel (indices >= CH_NUM are ignored)
//   wr_div       : new divisor D (period D+1 count cycles)
//   wr_run       : 1 = start channel, 0 = stop
//   wr_oneshot   : 1 = one-shot, 0 = periodic
//   tick         : per-channel one-clock tick pulse
//   running      : per-channel registered run status
// -----------------------------------------------------------------------------
module device_tick_gen
    import io_tick_pkg::*;
#(
    parameter int unsigned CH_NUM      = 4,
    parameter int unsigned CNT_W       = TICK_CNT_W,
    parameter int unsigned DEFAULT_DIV = TICK_DEFAULT_DIV,
    parameter bit          RESET_EN    = 1'b1,
    parameter int unsigned PRESCALE    = 100,
    localparam int unsigned CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
    input  logic              wr_run,
    input  logic              wr_oneshot,
    output logic [CH_NUM-1:0] tick,
    output logic [CH_NUM-1:0] running
);

    logic ce;

`ifdef TICK_GEN_PRESCALE_EN
    localparam int unsigned PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    assign ce = (pre_q == PRE_W'(PRESCALE - 1));

    always_comb begin
        pre_d = ce ? '0 : pre_q + PRE_W'(1);
    end

    // Free-running; only reset clears it, writes leave its phase alone.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    logic unused_prescale;

    assign ce              = 1'b1;
    assign unused_prescale = (PRESCALE != 0);
`endif

    tick_mode_e wr_mode;

    assign wr_mode = tick_mode_e'(wr_oneshot);

    // Out-of-range wr_ch never equals a valid index, so it selects nothing.
    for (genvar i = 0; i < int'(CH_NUM); i++) begin : g_ch
        logic wr_sel;

        assign wr_sel = wr_en && (wr_ch == CH_W'(i));

        tick_channel #(
            .CNT_W      (CNT_W),
            .DEFAULT_DIV(DEFAULT_DIV),
            .RESET_EN   (RESET_EN)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .ce     (ce),
            .wr_sel (wr_sel),
            .wr_div (wr_div),
            .wr_run (wr_run),
            .wr_mode(wr_mode),
            .tick   (tick[i]),
            .running(running[i])
        );
    end

endmodule

// File: tb/tb_device_tick_gen.sv
// -----------------------------------------------------------------------------
// tb_device_tick_gen
// Directed stimulus for device_tick_gen. A reference schedule (write/reset
// cycle, period, mode per channel) predicts tick/running for every cycle;
// predictions are queued as each cycle's stimulus is driven and compared at
// the following negedge. A second, 3-channel instance checks that an
// out-of-range channel index is ignored.
// -----------------------------------------------------------------------------
module tb_device_tick_gen;

    localparam int CH   = 4;
    localparam int CH2  = 3;
    localparam int DDIV = 4;
`ifdef TICK_GEN_PRESCALE_EN
    localparam int PRE  = 3;
`else
    localparam int PRE  = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [1:0]    wr_ch;
    logic [15:0]   wr_div;
    logic          wr_run;
    logic          wr_oneshot;
    logic [CH-1:0] tick;
    logic [CH-1:0] running;

    logic           wr_en2;
    logic [1:0]     wr_ch2;
    logic [CH2-1:0] tick2;
    logic [CH2-1:0] running2;

    device_tick_gen #(
        .CH_NUM     (CH),
        .CNT_W      (16),
        .DEFAULT_DIV(DDIV),
        .RESET_EN   (1'b1),
        .PRESCALE   (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_div    (wr_div),
        .wr_run    (wr_run),
        .wr_oneshot(wr_oneshot),
        .tick      (tick),
        .running   (running)
    );

    device_tick_gen #(
        .CH_NUM     (CH2),
        .CNT_W      (16),
        .DEFAULT_DIV(DDIV),
        .RESET_EN   (1'b1),
        .PRESCALE   (3)
    ) dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en2),
        .wr_ch     (wr_ch2),
        .wr_div    (wr_div),
        .wr_run    (wr_run),
        .wr_oneshot(wr_oneshot),
        .tick      (tick2),
        .running   (running2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Reference schedule: cycle in which cnt was 0 after the last write/reset.
    int base [CH];
    int per  [CH];
    bit srun [CH];
    bit sos  [CH];
    int rbase;
    int base2;

    string cur_tag;

    typedef struct {
        int             c;
        logic [CH-1:0]  t;
        logic [CH-1:0]  r;
        logic [CH2-1:0] t2;
        logic [CH2-1:0] r2;
        string          tag;
    } exp_t;

    exp_t sbq[$];

    function automatic bit ce_at(int c);
        if (PRE == 1) return 1'b1;
        return ((c - rbase) % PRE) == PRE - 1;
    endfunction

    // Number of count-enable cycles in [b, c].
    function automatic int nce(int b, int c);
        int n = 0;
        for (int k = b; k <= c; k++) if (ce_at(k)) n++;
        return n;
    endfunction

    function automatic bit exp_tick(int b, int p, bit r, bit os, int c);
        int n;
        if (!r || !ce_at(c)) return 1'b0;
        n = nce(b, c);
        if (os) return n == p;
        return (n % p) == 0;
    endfunction

    function automatic bit exp_run(int b, int p, bit r, bit os, int c);
        if (!r) return 1'b0;
        if (!os) return 1'b1;
        return nce(b, c - 1) < p;
    endfunction

    task automatic push_cur();
        exp_t e;
        e.c   = cyc;
        e.tag = cur_tag;
        for (int i = 0; i < CH; i++) begin
            e.t[i] = exp_tick(base[i], per[i], srun[i], sos[i], cyc);
            e.r[i] = exp_run(base[i], per[i], srun[i], sos[i], cyc);
        end
        for (int i = 0; i < CH2; i++) begin
            e.t2[i] = exp_tick(base2, DDIV + 1, 1'b1, 1'b0, cyc);
            e.r2[i] = 1'b1;
        end
        sbq.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        push_cur();
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic reset_sched();
        rbase = cyc;
        base2 = cyc;
        for (int i = 0; i < CH; i++) begin
            base[i] = cyc;
            per[i]  = DDIV + 1;
            srun[i] = 1'b1;
            sos[i]  = 1'b0;
        end
    endtask

    // Drive the write during the current cycle; it takes effect at the next edge.
    task automatic do_write(int ch, int div, bit r, bit os);
        wr_en      = 1'b1;
        wr_ch      = 2'(ch);
        wr_div     = 16'(div);
        wr_run     = r;
        wr_oneshot = os;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        base[ch] = cyc;
        per[ch]  = div + 1;
        srun[ch] = r;
        sos[ch]  = os;
        push_cur();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_sched();
        push_cur();
    endtask

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            total++;
            assert (tick === e.t) else begin
                bad++;
                $error("FAIL %s tick cyc=%0d observed=%b expected=%b", e.tag, e.c, tick, e.t);
            end
            total++;
            assert (running === e.r) else begin
                bad++;
                $error("FAIL %s running cyc=%0d observed=%b expected=%b", e.tag, e.c, running, e.r);
            end
            total++;
            assert (tick2 === e.t2) else begin
                bad++;
                $error("FAIL %s tick2 cyc=%0d observed=%b expected=%b", e.tag, e.c, tick2, e.t2);
            end
            total++;
            assert (running2 === e.r2) else begin
                bad++;
                $error("FAIL %s running2 cyc=%0d observed=%b expected=%b", e.tag, e.c, running2, e.r2);
            end
        end
    end

    initial begin
        bit found;
        rst_n      = 1'b0;
        wr_en      = 1'b0;
        wr_ch      = '0;
        wr_div     = '0;
        wr_run     = 1'b0;
        wr_oneshot = 1'b0;
        wr_en2     = 1'b0;
        wr_ch2     = '0;

        // Reset held over two edges, released after the second.
        cur_tag = "reset_period";
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        reset_sched();
        push_cur();
        run(12 * PRE);

        cur_tag = "ch2_div0";
        do_write(2, 0, 1'b1, 1'b0);
        run(10 * PRE);

        cur_tag = "ch1_oneshot";
        do_write(1, 3, 1'b1, 1'b1);
        run(60 * PRE);

        // Line the write up with a tick[0] cycle (bounded search).
        cur_tag = "ch0_wr_on_tick";
        found = 1'b0;
        for (int k = 0; k < 20 * PRE; k++) begin
            if (exp_tick(base[0], per[0], srun[0], sos[0], cyc)) begin
                found = 1'b1;
                break;
            end
            step();
        end
        total++;
        assert (found === 1'b1) else begin
            bad++;
            $error("FAIL ch0_tick_search observed=%b expected=%b", found, 1'b1);
        end
        do_write(0, 7, 1'b1, 1'b0);
        run(20 * PRE);

        cur_tag = "ch2_stop";
        do_write(2, 5, 1'b0, 1'b0);
        run(6 * PRE);

        // Reset with ch3 mid-count (cnt=2, div=9).
        cur_tag = "ch3_reset_midcount";
        do_write(3, 9, 1'b1, 1'b0);
        run(2);
        do_reset();
        run(12 * PRE);

        // Out-of-range channel on the 3-channel instance: must be ignored.
        cur_tag = "oob_channel";
        wr_en2     = 1'b1;
        wr_ch2     = 2'd3;
        wr_div     = 16'd0;
        wr_run     = 1'b0;
        wr_oneshot = 1'b1;
        step();
        wr_en2 = 1'b0;
        run(12 * PRE);

`ifdef TICK_GEN_PRESCALE_EN
        cur_tag = "prescale_ch0_div1";
        do_write(0, 1, 1'b1, 1'b0);
        run(20);
`endif

        @(negedge clk);
        #1;
        total++;
        assert (sbq.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_drain observed=%0d expected=%0d", sbq.size(), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
